rf_writeback_queue: RTL and testbench

//  Write-side master for the register file: drives WEN/wsel/wdat.

---
 rtl/rf_writeback_queue.sv | 124 ++++++++++++
 tb/tb_rf_writeback_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_queue.sv
// Ordered register-file writeback queue merging load-return and ALU writes.
// Define RF_WBQ_FWD_EN to add the fwd_sel/fwd_hit/fwd_dat forwarding lookup.
`timescale 1ns/1ps
module rf_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [ADDR_W-1:0]         mem_wsel,
  input  logic [DATA_W-1:0]         mem_wdat,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [ADDR_W-1:0]         alu_wsel,
  input  logic [DATA_W-1:0]         alu_wdat,
  output logic                      rf_wen,
  output logic [ADDR_W-1:0]         rf_wsel,
  output logic [DATA_W-1:0]         rf_wdat,
  output logic [(1<<ADDR_W)-1:0]    busy,
  output logic [$clog2(DEPTH):0]    count
`ifdef RF_WBQ_FWD_EN
  ,
  input  logic [ADDR_W-1:0]         fwd_sel,
  output logic                      fwd_hit,
  output logic [DATA_W-1:0]         fwd_dat
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] wsel_q [DEPTH];
  logic [DATA_W-1:0] wdat_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] alu_slot;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] space;
  logic          nonempty;
  logic          enq_mem, enq_alu;
  logic [DEPTH-1:0] live;

  assign nonempty = count_q != '0;

  // The head always retires this cycle, so its slot counts as free.
  assign space = CW'(DEPTH) - count_q + CW'(nonempty);

  assign mem_ready = space >= CW'(1);
  assign alu_ready = space >= (mem_valid ? CW'(2) : CW'(1));

  assign enq_mem = mem_valid & mem_ready & (mem_wsel != '0);
  assign enq_alu = alu_valid & alu_ready & (alu_wsel != '0);

  assign alu_slot = enq_mem ? tail_q + PW'(1) : tail_q;

  always_comb begin
    head_d  = head_q + PW'(nonempty);
    tail_d  = tail_q + PW'(enq_mem) + PW'(enq_alu);
    count_d = count_q - CW'(nonempty)
            + CW'(enq_mem) + CW'(enq_alu);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && enq_mem) begin
      wsel_q[tail_q] <= mem_wsel;
      wdat_q[tail_q] <= mem_wdat;
    end
    if (!RST && enq_alu) begin
      wsel_q[alu_slot] <= alu_wsel;
      wdat_q[alu_slot] <= alu_wdat;
    end
  end

  assign rf_wen  = nonempty;
  assign rf_wsel = nonempty ? wsel_q[head_q] : '0;
  assign rf_wdat = nonempty ? wdat_q[head_q] : '0;
  assign count   = count_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_live
    logic [PW-1:0] off;
    assign off     = PW'(g) - head_q;
    assign live[g] = {1'b0, off} < count_q;
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i]) busy[wsel_q[i]] = 1'b1;
    end
    busy[0] = 1'b0;
  end

`ifdef RF_WBQ_FWD_EN
  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_dat = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q && fwd_sel != '0 &&
          wsel_q[head_q + PW'(k)] == fwd_sel) begin
        fwd_hit = 1'b1;
        fwd_dat = wdat_q[head_q + PW'(k)];
      end
    end
  end
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Bench for rf_writeback_queue: directed table, corner sequences, random vs queue model.
`timescale 1ns/1ps
module tb_rf_writeback_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic CLK = 1'b0;
  logic RST;
  logic mem_valid, mem_ready;
  logic [ADDR_W-1:0] mem_wsel;
  logic [DATA_W-1:0] mem_wdat;
  logic alu_valid, alu_ready;
  logic [ADDR_W-1:0] alu_wsel;
  logic [DATA_W-1:0] alu_wdat;
  logic rf_wen;
  logic [ADDR_W-1:0] rf_wsel;
  logic [DATA_W-1:0] rf_wdat;
  logic [(1<<ADDR_W)-1:0] busy;
  logic [$clog2(DEPTH):0] count;
`ifdef RF_WBQ_FWD_EN
  logic [ADDR_W-1:0] fwd_sel;
  logic fwd_hit;
  logic [DATA_W-1:0] fwd_dat;
`endif

  rf_writeback_queue #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .CLK(CLK), .RST(RST),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wsel(mem_wsel), .mem_wdat(mem_wdat),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_wsel(alu_wsel), .alu_wdat(alu_wdat),
    .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
    .busy(busy), .count(count)
`ifdef RF_WBQ_FWD_EN
    ,
    .fwd_sel(fwd_sel), .fwd_hit(fwd_hit), .fwd_dat(fwd_dat)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [ADDR_W-1:0] sel;
    logic [DATA_W-1:0] dat;
  } ent_t;

  ent_t mq[$];
  bit   known = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int space_now();
    int n;
    n = mq.size();
    return DEPTH - n + ((n != 0) ? 1 : 0);
  endfunction

  task automatic set_in(input bit r,
                        input bit mv, input logic [ADDR_W-1:0] mw,
                        input logic [DATA_W-1:0] md,
                        input bit av, input logic [ADDR_W-1:0] aw,
                        input logic [DATA_W-1:0] ad);
    RST = r;
    mem_valid = mv; mem_wsel = mw; mem_wdat = md;
    alu_valid = av; alu_wsel = aw; alu_wdat = ad;
`ifdef RF_WBQ_FWD_EN
    fwd_sel = ADDR_W'($urandom_range(0, 7));
`endif
    #1;
  endtask

  task automatic model_check();
    int n;
    logic [31:0] eb;
    logic [ADDR_W-1:0] es;
    logic [DATA_W-1:0] ed;
    bit er;
`ifdef RF_WBQ_FWD_EN
    bit eh;
    logic [DATA_W-1:0] efd;
`endif
    if (!known) return;
    n  = mq.size();
    eb = '0;
    foreach (mq[i]) eb[mq[i].sel] = 1'b1;
    eb[0] = 1'b0;
    es = (n != 0) ? mq[0].sel : '0;
    ed = (n != 0) ? mq[0].dat : '0;
    er = space_now() >= (mem_valid ? 2 : 1);
    check("m.rf_wen", 64'(rf_wen), 64'(n != 0));
    check("m.rf_wsel", 64'(rf_wsel), 64'(es));
    check("m.rf_wdat", 64'(rf_wdat), 64'(ed));
    check("m.count", 64'(count), 64'(n));
    check("m.busy", 64'(busy), 64'(eb));
    check("m.mem_ready", 64'(mem_ready), 64'(space_now() >= 1));
    check("m.alu_ready", 64'(alu_ready), 64'(er));
`ifdef RF_WBQ_FWD_EN
    eh = 1'b0;
    efd = '0;
    foreach (mq[i]) begin
      if (fwd_sel != '0 && mq[i].sel == fwd_sel) begin
        eh = 1'b1;
        efd = mq[i].dat;
      end
    end
    check("m.fwd_hit", 64'(fwd_hit), 64'(eh));
    check("m.fwd_dat", 64'(fwd_dat), 64'(efd));
`endif
  endtask

  task automatic tick();
    int sp;
    bit mr, ar;
    sp = space_now();
    mr = sp >= 1;
    ar = sp >= (mem_valid ? 2 : 1);
    @(posedge CLK);
    if (RST) begin
      mq.delete();
      known = 1'b1;
    end else begin
      if (mq.size() != 0) void'(mq.pop_front());
      if (mem_valid && mr && mem_wsel != '0)
        mq.push_back('{mem_wsel, mem_wdat});
      if (alu_valid && ar && alu_wsel != '0)
        mq.push_back('{alu_wsel, alu_wdat});
    end
    #1;
  endtask

  typedef struct {
    bit rst;
    bit mv; logic [ADDR_W-1:0] mw; logic [DATA_W-1:0] md;
    bit av; logic [ADDR_W-1:0] aw; logic [DATA_W-1:0] ad;
    bit chk;
    bit wen; logic [ADDR_W-1:0] wsel; logic [DATA_W-1:0] wdat;
    int cnt; bit mr; bit ar; logic [31:0] bsy;
  } vec_t;

  vec_t vt[11];

  initial begin
    // expected fields describe outputs while that row's inputs are applied
    vt[0]  = '{1'b1, 1'b1, 5'd7, 32'hAA, 1'b1, 5'd8, 32'hBB, 1'b0,
               1'b0, 5'd0, 32'h0, 0, 1'b1, 1'b1, 32'h0};
    vt[1]  = '{1'b1, 1'b1, 5'd7, 32'hAA, 1'b1, 5'd8, 32'hBB, 1'b1,
               1'b0, 5'd0, 32'h0, 0, 1'b1, 1'b1, 32'h0};
    vt[2]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
               1'b0, 5'd0, 32'h0, 0, 1'b1, 1'b1, 32'h0};
    vt[3]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1,
               1'b0, 5'd0, 32'h0, 0, 1'b1, 1'b1, 32'h0};
    vt[4]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
               1'b1, 5'd3, 32'hDEAD_BEEF, 1, 1'b1, 1'b1, 32'h8};
    vt[5]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
               1'b0, 5'd0, 32'h0, 0, 1'b1, 1'b1, 32'h0};
    vt[6]  = '{1'b0, 1'b1, 5'd5, 32'h1, 1'b1, 5'd5, 32'h2, 1'b1,
               1'b0, 5'd0, 32'h0, 0, 1'b1, 1'b1, 32'h0};
    vt[7]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
               1'b1, 5'd5, 32'h1, 2, 1'b1, 1'b1, 32'h20};
    vt[8]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
               1'b1, 5'd5, 32'h2, 1, 1'b1, 1'b1, 32'h20};
    vt[9]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55, 1'b1,
               1'b0, 5'd0, 32'h0, 0, 1'b1, 1'b1, 32'h0};
    vt[10] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
               1'b0, 5'd0, 32'h0, 0, 1'b1, 1'b1, 32'h0};

    for (int i = 0; i < 11; i++) begin
      set_in(vt[i].rst, vt[i].mv, vt[i].mw, vt[i].md,
             vt[i].av, vt[i].aw, vt[i].ad);
      if (vt[i].chk) begin
        check($sformatf("v%0d.rf_wen", i), 64'(rf_wen), 64'(vt[i].wen));
        check($sformatf("v%0d.rf_wsel", i), 64'(rf_wsel), 64'(vt[i].wsel));
        check($sformatf("v%0d.rf_wdat", i), 64'(rf_wdat), 64'(vt[i].wdat));
        check($sformatf("v%0d.count", i), 64'(count), 64'(vt[i].cnt));
        check($sformatf("v%0d.mem_ready", i), 64'(mem_ready), 64'(vt[i].mr));
        check($sformatf("v%0d.alu_ready", i), 64'(alu_ready), 64'(vt[i].ar));
        check($sformatf("v%0d.busy", i), 64'(busy), 64'(vt[i].bsy));
      end
      model_check();
      tick();
    end

    // fill with both sources every cycle; pointers wrap several times
    for (int c = 0; c < 8; c++) begin
      set_in(1'b0, 1'b1, 5'(1 + c), 32'(32'h100 + c),
             1'b1, 5'(16 + c), 32'(32'h200 + c));
      if (c == 3) begin
        check("fill.count", 64'(count), 64'(4));
        check("fill.alu_ready", 64'(alu_ready), 64'(0));
        check("fill.mem_ready", 64'(mem_ready), 64'(1));
      end
      model_check();
      tick();
    end
    for (int c = 0; c < 6; c++) begin
      set_in(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
      model_check();
      tick();
    end
    check("drain.count", 64'(count), 64'(0));

    // mid-operation reset with three pending writes
    set_in(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    model_check();
    tick();
    set_in(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    model_check();
    tick();
    set_in(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    check("midrst.count_before", 64'(count), 64'(3));
    model_check();
    tick();
    for (int c = 0; c < 3; c++) begin
      set_in(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
      check($sformatf("midrst.rf_wen%0d", c), 64'(rf_wen), 64'(0));
      check($sformatf("midrst.busy%0d", c), 64'(busy), 64'(0));
      model_check();
      tick();
    end

`ifdef RF_WBQ_FWD_EN
    set_in(1'b0, 1'b1, 5'd5, 32'd7, 1'b1, 5'd5, 32'd9);
    model_check();
    tick();
    set_in(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    fwd_sel = 5'd5;
    #1;
    check("fwd.hit", 64'(fwd_hit), 64'(1));
    check("fwd.dat", 64'(fwd_dat), 64'(9));
    fwd_sel = 5'd6;
    #1;
    check("fwd.miss_hit", 64'(fwd_hit), 64'(0));
    check("fwd.miss_dat", 64'(fwd_dat), 64'(0));
    model_check();
    tick();
`endif

    for (int c = 0; c < 400; c++) begin
      set_in($urandom_range(0, 49) == 0,
             $urandom_range(0, 3) != 0, ADDR_W'($urandom_range(0, 7)),
             $urandom,
             $urandom_range(0, 3) != 0, ADDR_W'($urandom_range(0, 7)),
             $urandom);
      model_check();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
